// File: rtl/dot_matrix_scanner_if.sv
// rtl/dot_matrix_scanner_if.sv - host/display signal bundle for the dot matrix scanner
interface dot_matrix_scanner_if #(
  parameter int ROWS  = 16,
  parameter int SEL_W = 4
);
  logic [ROWS-1:0]  in_column;
  logic [SEL_W-1:0] in_index;
  logic             LOAD;
  logic             IN_CLR;
  logic             SWAP;
  logic [SEL_W-1:0] column_seg;
  logic [ROWS-1:0]  out_column;
  logic             COLUMN_CLK;
  logic             OUT_CLR;
  logic             FRAME_END;
  logic             swap_pending;

  modport master (
    output in_column, in_index, LOAD, IN_CLR, SWAP,
    input  column_seg, out_column, COLUMN_CLK, OUT_CLR, FRAME_END, swap_pending
  );

  modport slave (
    input  in_column, in_index, LOAD, IN_CLR, SWAP,
    output column_seg, out_column, COLUMN_CLK, OUT_CLR, FRAME_END, swap_pending
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - double-buffered column-scan LED matrix driver
module dot_matrix_scanner #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int SEL_W    = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  dot_matrix_scanner_if.slave bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]           div_cnt, div_nxt;
  logic [SEL_W-1:0]           column, col_nxt;
  logic [COLS-1:0][ROWS-1:0]  front, back, front_nxt, back_nxt;
  logic                       load_q;
  logic                       swap_pending_q, swap_pending_nxt;
  logic                       div_last, col_last, boundary, do_swap, write_edge;
  logic [ROWS-1:0]            row_nxt;

  always_comb begin
    div_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    col_last = (column == SEL_W'(COLS - 1));
    boundary = div_last && col_last;

    div_nxt = div_last ? '0 : div_cnt + 1'b1;
    col_nxt = column;
    if (div_last) begin
      col_nxt = col_last ? '0 : column + 1'b1;
    end

    // The swap copies the pre-edge back buffer, so a same-cycle write only lands in back.
    do_swap   = boundary && (swap_pending_q || bus.SWAP);
    front_nxt = do_swap ? back : front;

    swap_pending_nxt = swap_pending_q;
    if (do_swap) begin
      swap_pending_nxt = 1'b0;
    end else if (bus.SWAP) begin
      swap_pending_nxt = 1'b1;
    end

    // An index at or beyond COLS matches no column, so such writes fall away.
    write_edge = bus.LOAD && !load_q;
    back_nxt   = back;
    if (bus.IN_CLR) begin
      back_nxt = '0;
    end else if (write_edge) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.in_index == SEL_W'(c)) begin
          back_nxt[c] = bus.in_column;
        end
      end
    end

    row_nxt = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_nxt == SEL_W'(c)) begin
        row_nxt = front_nxt[c];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_cnt          <= '0;
      column           <= '0;
      front            <= '0;
      back             <= '0;
      load_q           <= 1'b1;
      swap_pending_q   <= 1'b0;
      bus.column_seg   <= '0;
      bus.out_column   <= '0;
      bus.COLUMN_CLK   <= 1'b0;
      bus.OUT_CLR      <= 1'b1;
      bus.FRAME_END    <= 1'b0;
      bus.swap_pending <= 1'b0;
    end else begin
      div_cnt          <= div_nxt;
      column           <= col_nxt;
      front            <= front_nxt;
      back             <= back_nxt;
      load_q           <= bus.LOAD;
      swap_pending_q   <= swap_pending_nxt;
      // Outputs carry the decode of the state being entered, keeping them fully registered.
      bus.column_seg   <= col_nxt;
      bus.COLUMN_CLK   <= (div_nxt == '0);
      bus.OUT_CLR      <= (32'(div_nxt) < BLANK);
      bus.out_column   <= (32'(div_nxt) >= BLANK) ? row_nxt : '0;
      bus.FRAME_END    <= boundary;
      bus.swap_pending <= swap_pending_nxt;
    end
  end
endmodule
